// File: rtl/image_scale_ctrl_if.sv
// Handshake and bus bundle between the requantisation scale sequencer and its neighbours:
// scale parameter stream, accumulator FIFO, output FIFO back-pressure and the multiplier B bus.
interface image_scale_ctrl_if #(
  parameter int WIDTH_DATA_ADD          = 32,
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8
);
  logic                                              scale_in_valid;
  logic [WIDTH_DATA_ADD-1:0]                         scale_in_data;
  logic                                              scale_in_ready;
  logic                                              s_valid;
  logic                                              s_ready;
  logic                                              out_almost_full;
  logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] scale_data;
  logic                                              mult_valid;

  modport master (
    output scale_in_valid, scale_in_data, s_valid, out_almost_full,
    input  scale_in_ready, s_ready, scale_data, mult_valid
  );

  modport slave (
    input  scale_in_valid, scale_in_data, s_valid, out_almost_full,
    output scale_in_ready, s_ready, scale_data, mult_valid
  );
endinterface

// File: rtl/image_scale_ctrl.sv
// Sequences the per-channel requantisation multiplier array: loads a per-group scale table, then drives
// the scale bus group-by-group while accumulator words stream in, with a valid aligned to the multiplier.
module image_scale_ctrl #(
  parameter int WIDTH_DATA_ADD          = 32,
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_FEATURE_SIZE      = 10,
  parameter int MAX_GROUPS              = 64,
  parameter int GROUP_W                 = 7,
  parameter int MULT_LATENCY            = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [GROUP_W-1:0]              cfg_group_num,
  input  logic [2*WIDTH_FEATURE_SIZE-1:0] cfg_pixel_num,
  image_scale_ctrl_if.slave               bus,
  output logic                            busy,
  output logic                            done
);

  localparam int PIX_W  = 2*WIDTH_FEATURE_SIZE;
  localparam int CH_W   = (COMPUTE_CHANNEL_OUT_NUM > 1) ? $clog2(COMPUTE_CHANNEL_OUT_NUM) : 1;
  localparam int GIDX_W = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
  localparam int DR_W   = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam int ROW_W  = COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_next;
  logic [GROUP_W-1:0]   grp_num_r, load_grp, grp_cnt;
  logic [PIX_W-1:0]     pix_num_r, pix_cnt;
  logic [CH_W-1:0]      load_ch;
  logic [DR_W-1:0]      drain_cnt;
  logic [MULT_LATENCY-1:0] valid_sr;
  logic [ROW_W-1:0]     scale_data_r, row0_next;
  logic [ROW_W-1:0]     scale_tbl [MAX_GROUPS];
  logic [GIDX_W-1:0]    next_idx;
  logic                 scale_ready, acc_ready, load_fire, acc_fire;
  logic                 load_last, pix_last, grp_last, cfg_bad;

  assign cfg_bad   = (cfg_group_num == '0) || (cfg_pixel_num == '0) ||
                     (cfg_group_num > GROUP_W'(MAX_GROUPS));
  assign load_fire = scale_ready & bus.scale_in_valid;
  assign acc_fire  = acc_ready;
  assign load_last = (load_ch == CH_W'(COMPUTE_CHANNEL_OUT_NUM-1)) &&
                     (load_grp == grp_num_r - GROUP_W'(1));
  assign pix_last  = (pix_cnt == pix_num_r - PIX_W'(1));
  assign grp_last  = (grp_cnt == grp_num_r - GROUP_W'(1));
  assign next_idx  = grp_cnt[GIDX_W-1:0] + GIDX_W'(1);

  assign bus.scale_in_ready = scale_ready;
  assign bus.s_ready        = acc_ready;
  assign bus.scale_data     = scale_data_r;
  assign bus.mult_valid     = valid_sr[MULT_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Drain is one cycle shorter than the latency so done lines up with the last mult_valid.
  always_comb begin
    state_next  = state;
    scale_ready = 1'b0;
    acc_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = cfg_bad ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        scale_ready = 1'b1;
        if (bus.scale_in_valid && load_last) state_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        acc_ready = bus.s_valid & ~bus.out_almost_full;
        if (acc_ready && pix_last && grp_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt >= DR_W'(MULT_LATENCY-2)) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // When there is a single group, row 0 is still completing on the LOAD->RUN edge; bypass the last word.
  always_comb begin
    row0_next = scale_tbl[0];
    if (load_grp == '0)
      row0_next[load_ch*WIDTH_DATA_ADD +: WIDTH_DATA_ADD] = bus.scale_in_data;
  end

  always_ff @(posedge clk) begin
    if (load_fire)
      scale_tbl[load_grp[GIDX_W-1:0]][load_ch*WIDTH_DATA_ADD +: WIDTH_DATA_ADD] <= bus.scale_in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_num_r    <= '0;
      pix_num_r    <= '0;
      load_grp     <= '0;
      load_ch      <= '0;
      grp_cnt      <= '0;
      pix_cnt      <= '0;
      drain_cnt    <= '0;
      valid_sr     <= '0;
      scale_data_r <= '0;
    end else begin
      valid_sr <= {valid_sr[MULT_LATENCY-2:0], acc_fire};
      if (state == S_IDLE && start) begin
        grp_num_r <= cfg_group_num;
        pix_num_r <= cfg_pixel_num;
        load_grp  <= '0;
        load_ch   <= '0;
        grp_cnt   <= '0;
        pix_cnt   <= '0;
        drain_cnt <= '0;
      end
      if (load_fire) begin
        if (load_ch == CH_W'(COMPUTE_CHANNEL_OUT_NUM-1)) begin
          load_ch  <= '0;
          load_grp <= load_grp + GROUP_W'(1);
          if (load_last) scale_data_r <= row0_next;
        end else begin
          load_ch <= load_ch + CH_W'(1);
        end
      end
      // The bus switches on the edge that retires a group's last pixel, so B is ready for the next A.
      if (acc_fire) begin
        if (pix_last) begin
          pix_cnt <= '0;
          grp_cnt <= grp_cnt + GROUP_W'(1);
          if (!grp_last) scale_data_r <= scale_tbl[next_idx];
        end else begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DR_W'(1);
    end
  end

endmodule

// File: tb/tb_image_scale_ctrl.sv
// Directed bench for image_scale_ctrl: scale table load, group switching, back-pressure,
// degenerate configs, mid-job reset and ignored restart.
module tb_image_scale_ctrl;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int WF = 10;
  localparam int MG = 64;
  localparam int GW = 7;
  localparam int ML = 6;
  localparam int RW = C*W;

  localparam logic [RW-1:0] ROW0 = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [RW-1:0] ROW1 = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9};

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [GW-1:0]   cfg_group_num;
  logic [2*WF-1:0] cfg_pixel_num;
  logic            busy;
  logic            done;

  image_scale_ctrl_if #(.WIDTH_DATA_ADD(W), .COMPUTE_CHANNEL_OUT_NUM(C)) bus ();

  image_scale_ctrl #(
    .WIDTH_DATA_ADD(W), .COMPUTE_CHANNEL_OUT_NUM(C), .WIDTH_FEATURE_SIZE(WF),
    .MAX_GROUPS(MG), .GROUP_W(GW), .MULT_LATENCY(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_group_num(cfg_group_num),
    .cfg_pixel_num(cfg_pixel_num), .bus(bus.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt, mv_cnt, done_cnt, busy_cnt, ld_cnt, rdy_cnt, leak, blocked;
  int first_acc, last_acc, first_mv, last_mv, done_cyc, start_cyc;
  logic [RW-1:0] acc_scale [0:599];

  always @(posedge clk) cyc++;

  // Observes the DUT mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready) begin
      if (acc_cnt < 600) acc_scale[acc_cnt] = bus.scale_data;
      if (acc_cnt == 0) first_acc = cyc;
      last_acc = cyc;
      acc_cnt++;
    end
    if (bus.mult_valid) begin
      if (mv_cnt == 0) first_mv = cyc;
      last_mv = cyc;
      mv_cnt++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (busy) busy_cnt++;
    if (bus.scale_in_ready) rdy_cnt++;
    if (bus.scale_in_valid && bus.scale_in_ready) ld_cnt++;
    if (bus.out_almost_full && bus.s_ready) leak++;
    if (bus.out_almost_full && bus.s_valid) blocked++;
    if (start) start_cyc = cyc;
  end

  task automatic clear_mon();
    acc_cnt = 0; mv_cnt = 0; done_cnt = 0; busy_cnt = 0; ld_cnt = 0; rdy_cnt = 0;
    leak = 0; blocked = 0;
    first_acc = -1; last_acc = -1; first_mv = -1; last_mv = -1; done_cyc = -1; start_cyc = -1;
  endtask

  task automatic start_job(input int g, input int p);
    @(posedge clk); #1;
    cfg_group_num = GW'(g);
    cfg_pixel_num = (2*WF)'(p);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input int base, input int extra);
    int  sent  = 0;
    int  guard = 0;
    logic hs;
    bus.scale_in_valid = 1'b1;
    bus.scale_in_data  = W'(base);
    while (sent < n && guard < 4000) begin
      @(negedge clk);
      hs = bus.scale_in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        bus.scale_in_data = W'(base + sent);
      end
      guard++;
    end
    total++;
    if (sent != n) begin
      bad++;
      $display("[TB] FAIL load_timeout got=%0d words want=%0d", sent, n);
    end
    repeat (extra) begin
      @(posedge clk); #1;
    end
    bus.scale_in_valid = 1'b0;
  endtask

  task automatic feed_pixels(input bit toggle, input int afull_at, input int afull_len,
                             input int restart_at);
    int k = 0;
    while (done_cnt == 0 && k < 2000) begin
      bus.s_valid         = toggle ? (k % 2 == 0) : 1'b1;
      bus.out_almost_full = (k >= afull_at) && (k < afull_at + afull_len);
      start               = (k == restart_at);
      if (k == restart_at) begin
        cfg_group_num = GW'(1);
        cfg_pixel_num = (2*WF)'(1);
      end
      @(posedge clk); #1;
      k++;
    end
    bus.s_valid = 1'b0;
    bus.out_almost_full = 1'b0;
    start = 1'b0;
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("[TB] FAIL done_timeout got=%0d cycles want=done", k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    cfg_group_num = GW'(2);
    cfg_pixel_num = (2*WF)'(4);
    bus.scale_in_valid = 1'b1;
    bus.scale_in_data = '0;
    bus.s_valid = 1'b1;
    bus.out_almost_full = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0", done); end
    total++; if (bus.scale_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_scale_ready got=%b want=0", bus.scale_in_ready); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_s_ready got=%b want=0", bus.s_ready); end
    total++; if (bus.mult_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mult_valid got=%b want=0", bus.mult_valid); end
    total++; if (bus.scale_data !== '0) begin bad++; $display("[TB] FAIL rst_scale_data got=%h want=0", bus.scale_data); end
    start = 1'b0;
    bus.scale_in_valid = 1'b0;
    bus.s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_start_ignored got=%b want=0", busy); end
  endtask

  task automatic test_basic_job();
    clear_mon();
    start_job(2, 4);
    load_words(16, 1, 0);
    feed_pixels(1'b0, -1, 0, -1);
    total++; if (ld_cnt != 16) begin bad++; $display("[TB] FAIL t1_loads got=%0d want=16", ld_cnt); end
    total++; if (acc_cnt != 8) begin bad++; $display("[TB] FAIL t1_accepts got=%0d want=8", acc_cnt); end
    total++; if (mv_cnt != 8) begin bad++; $display("[TB] FAIL t1_mult_valid got=%0d want=8", mv_cnt); end
    total++; if (first_mv != first_acc + ML) begin bad++; $display("[TB] FAIL t1_first_mv got=%0d want=%0d", first_mv, first_acc + ML); end
    total++; if (done_cyc != last_acc + 6) begin bad++; $display("[TB] FAIL t1_done_cycle got=%0d want=%0d", done_cyc, last_acc + 6); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL t1_done_count got=%0d want=1", done_cnt); end
    total++; if (busy_cnt != 30) begin bad++; $display("[TB] FAIL t1_busy_cycles got=%0d want=30", busy_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (acc_scale[i] !== ((i < 4) ? ROW0 : ROW1)) begin
        bad++;
        $display("[TB] FAIL t1_scale_px%0d got=%h want=%h", i, acc_scale[i], (i < 4) ? ROW0 : ROW1);
      end
    end
    total++; if (bus.scale_data !== ROW1) begin bad++; $display("[TB] FAIL t1_idle_hold got=%h want=%h", bus.scale_data, ROW1); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    start_job(2, 4);
    load_words(16, 1, 0);
    feed_pixels(1'b1, 2, 3, -1);
    total++; if (leak != 0) begin bad++; $display("[TB] FAIL t2_ready_when_full got=%0d want=0", leak); end
    total++; if (blocked != 2) begin bad++; $display("[TB] FAIL t2_blocked_cycles got=%0d want=2", blocked); end
    total++; if (acc_cnt != 8) begin bad++; $display("[TB] FAIL t2_accepts got=%0d want=8", acc_cnt); end
    total++; if (mv_cnt != 8) begin bad++; $display("[TB] FAIL t2_mult_valid got=%0d want=8", mv_cnt); end
    total++; if (last_mv != last_acc + ML) begin bad++; $display("[TB] FAIL t2_last_mv got=%0d want=%0d", last_mv, last_acc + ML); end
    total++; if (acc_scale[3] !== ROW0) begin bad++; $display("[TB] FAIL t2_scale_px3 got=%h want=%h", acc_scale[3], ROW0); end
    total++; if (acc_scale[4] !== ROW1) begin bad++; $display("[TB] FAIL t2_scale_px4 got=%h want=%h", acc_scale[4], ROW1); end
  endtask

  task automatic test_degenerate();
    clear_mon();
    start_job(2, 0);
    repeat (5) @(posedge clk);
    #1;
    total++; if (rdy_cnt != 0) begin bad++; $display("[TB] FAIL t3_no_ready got=%0d want=0", rdy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL t3_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc != start_cyc + 1) begin bad++; $display("[TB] FAIL t3_done_cycle got=%0d want=%0d", done_cyc, start_cyc + 1); end
    total++; if (busy_cnt != 1) begin bad++; $display("[TB] FAIL t3_busy_cycles got=%0d want=1", busy_cnt); end
    clear_mon();
    start_job(65, 4);
    repeat (5) @(posedge clk);
    #1;
    total++; if (rdy_cnt != 0) begin bad++; $display("[TB] FAIL t3_over_no_ready got=%0d want=0", rdy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL t3_over_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_max_groups();
    logic [RW-1:0] exp_last;
    clear_mon();
    start_job(64, 1);
    load_words(512, 1, 8);
    feed_pixels(1'b0, -1, 0, -1);
    for (int j = 0; j < C; j++) exp_last[j*W +: W] = W'(505 + j);
    total++; if (ld_cnt != 512) begin bad++; $display("[TB] FAIL t4_loads got=%0d want=512", ld_cnt); end
    total++; if (rdy_cnt != 512) begin bad++; $display("[TB] FAIL t4_ready_cycles got=%0d want=512", rdy_cnt); end
    total++; if (mv_cnt != 64) begin bad++; $display("[TB] FAIL t4_mult_valid got=%0d want=64", mv_cnt); end
    total++; if (acc_scale[0] !== ROW0) begin bad++; $display("[TB] FAIL t4_scale_g0 got=%h want=%h", acc_scale[0], ROW0); end
    total++; if (acc_scale[63] !== exp_last) begin bad++; $display("[TB] FAIL t4_scale_g63 got=%h want=%h", acc_scale[63], exp_last); end
  endtask

  task automatic test_reset_mid_run();
    int k = 0;
    clear_mon();
    start_job(2, 4);
    load_words(16, 1, 0);
    while (acc_cnt < 3 && k < 200) begin
      bus.s_valid = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    #2;
    rst = 1'b0;
    #1;
    bus.s_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_busy got=%b want=0", busy); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("[TB] FAIL t5_s_ready got=%b want=0", bus.s_ready); end
    total++; if (bus.scale_data !== '0) begin bad++; $display("[TB] FAIL t5_scale_data got=%h want=0", bus.scale_data); end
    repeat (8) @(posedge clk);
    #1;
    total++; if (acc_cnt != 3) begin bad++; $display("[TB] FAIL t5_accepts got=%0d want=3", acc_cnt); end
    total++; if (mv_cnt != 0) begin bad++; $display("[TB] FAIL t5_mult_valid got=%0d want=0", mv_cnt); end
    rst = 1'b1;
    clear_mon();
    start_job(2, 4);
    load_words(16, 1, 0);
    feed_pixels(1'b0, -1, 0, -1);
    total++; if (mv_cnt != 8) begin bad++; $display("[TB] FAIL t5_rerun_mv got=%0d want=8", mv_cnt); end
    total++; if (acc_scale[7] !== ROW1) begin bad++; $display("[TB] FAIL t5_rerun_scale got=%h want=%h", acc_scale[7], ROW1); end
  endtask

  task automatic test_restart_ignored();
    clear_mon();
    start_job(2, 4);
    load_words(16, 1, 0);
    feed_pixels(1'b0, -1, 0, 3);
    repeat (4) @(posedge clk);
    #1;
    total++; if (acc_cnt != 8) begin bad++; $display("[TB] FAIL t6_accepts got=%0d want=8", acc_cnt); end
    total++; if (mv_cnt != 8) begin bad++; $display("[TB] FAIL t6_mult_valid got=%0d want=8", mv_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL t6_done_count got=%0d want=1", done_cnt); end
    total++; if (busy_cnt != 30) begin bad++; $display("[TB] FAIL t6_busy_cycles got=%0d want=30", busy_cnt); end
    total++; if (acc_scale[4] !== ROW1) begin bad++; $display("[TB] FAIL t6_scale_px4 got=%h want=%h", acc_scale[4], ROW1); end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_backpressure();
    test_degenerate();
    test_max_groups();
    test_reset_mid_run();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
